uart_tx_feeder: RTL



---
 rtl/uart_tx_feeder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of a UART transmitter: pops one byte at a time, pulses
// uart_start for it, then waits for a rising edge of uart_txDone (or a timeout).
module uart_tx_feeder #(
   parameter int DEPTH          = 16,
   parameter int START_CYCLES   = 2,
   parameter int GAP_CYCLES     = 1,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [7:0]             uart_tx_input,
   output logic                   uart_start,
   input  logic                   uart_txDone,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   busy,
   output logic                   timeout_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [SW-1:0] START_LAST = SW'(START_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [TW-1:0] WAIT_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

   state_t        state, state_nxt;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          push, pop;
   logic          done_q, done_rise;
   logic          timeout_hit;
   logic [SW-1:0] start_cnt;
   logic [GW-1:0] gap_cnt;
   logic [TW-1:0] wait_cnt;

   // in_ready depends only on the registered occupancy, so a full FIFO
   // refuses a push even in the cycle it is being popped.
   assign in_ready   = (count != (AW+1)'(DEPTH));
   assign push       = in_valid && in_ready;
   assign pop        = (state == IDLE) && (count != '0);
   assign fifo_count = count;
   assign uart_start = (state == START);
   assign busy       = (state != IDLE);
   assign done_rise  = uart_txDone & ~done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (rst)      uart_tx_input <= 8'h00;
      else if (pop) uart_tx_input <= mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (rst) done_q <= 1'b0;
      else     done_q <= uart_txDone;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Each counter runs only in its own state and is zero on entry to it.
   always_ff @(posedge clk) begin
      if (rst) begin
         start_cnt   <= '0;
         gap_cnt     <= '0;
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         start_cnt   <= (state == START)     ? start_cnt + 1'b1 : '0;
         gap_cnt     <= (state == GAP)       ? gap_cnt + 1'b1   : '0;
         wait_cnt    <= (state == WAIT_DONE) ? wait_cnt + 1'b1  : '0;
         timeout_err <= timeout_err | timeout_hit;
      end
   end

   always_comb begin
      state_nxt   = state;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) state_nxt = START;
         end
         START: begin
            if (start_cnt == START_LAST) state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (done_rise) begin
               state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
            end else if ((TIMEOUT_CYCLES > 0) && (wait_cnt == WAIT_LAST)) begin
               timeout_hit = 1'b1;
               state_nxt   = IDLE;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
